// File: rtl/dpi_sched_pkg.sv
// Shared types and default sizes for the DPI flow scheduler.
package dpi_sched_pkg;

  localparam int N_FLOW_DEF  = 16;
  localparam int FLOW_W_DEF  = 4;
  localparam int STATE_W_DEF = 11;

  // Scheduler FSM: swap contexts in and out of the single DFA engine.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_LOAD = 2'd2,
    ST_RUN  = 2'd3
  } sched_state_e;

  // One saved flow context: packet-level sticky match plus DFA state.
  typedef struct packed {
    logic                   match_sticky;
    logic [STATE_W_DEF-1:0] state;
  } ctx_entry_t;

endpackage

// File: rtl/dpi_ctx_ram.sv
// Per-flow context store: register array, one write port, async read.
module dpi_ctx_ram
  import dpi_sched_pkg::*;
#(
  parameter int DEPTH = N_FLOW_DEF,
  parameter int AW    = FLOW_W_DEF,
  parameter int W     = $bits(ctx_entry_t)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Contexts return to all-zero on reset; otherwise one entry per cycle is written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read is combinational so LOAD can restore in the same cycle it addresses.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dpi_flow_sched.sv
// Multiplexes interleaved per-flow byte streams onto one DFA engine by
// saving/restoring engine state per flow and reporting a per-packet verdict.
module dpi_flow_sched
  import dpi_sched_pkg::*;
#(
  parameter int N_FLOW  = N_FLOW_DEF,
  parameter int FLOW_W  = FLOW_W_DEF,
  parameter int STATE_W = STATE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [7:0]         s_data,
  input  logic [FLOW_W-1:0]  s_flow,
  input  logic               s_eop,
  input  logic               ctx_clr_vld,
  input  logic [FLOW_W-1:0]  ctx_clr_flow,
  output logic [7:0]         char_in,
  output logic               char_in_vld,
  output logic [STATE_W-1:0] state_in,
  output logic               state_in_vld,
  input  logic [STATE_W-1:0] state_out,
  input  logic               accept_out,
  output logic               res_vld,
  output logic [FLOW_W-1:0]  res_flow,
  output logic               res_match
);

  localparam int CTX_W = STATE_W + 1;

  sched_state_e        r_state, w_state_next;
  logic                r_loaded, w_loaded_next;
  logic [FLOW_W-1:0]   r_cur_flow, w_cur_flow_next;
  logic                r_pkt_match, w_pkt_match_next;
  logic                r_res_vld;
  logic [FLOW_W-1:0]   r_res_flow;
  logic                r_res_match;

  logic                w_clr_cur;
  logic                w_clr_load;
  logic                w_switch;
  logic                w_accept;
  logic                w_save_we;
  logic                w_we;
  logic [FLOW_W-1:0]   w_waddr;
  logic [CTX_W-1:0]    w_wdata;
  logic [CTX_W-1:0]    w_rdata;
  logic [STATE_W-1:0]  w_load_state;
  logic                w_load_match;

  // A clear aimed at the context currently living in the engine.
  assign w_clr_cur  = ctx_clr_vld && r_loaded && (ctx_clr_flow == r_cur_flow);
  // A clear aimed at the entry being read this cycle; the read sees zero.
  assign w_clr_load = ctx_clr_vld && (ctx_clr_flow == s_flow);
  // Incoming byte needs a different context than the one in the engine.
  assign w_switch   = s_valid && (!r_loaded || (s_flow != r_cur_flow));
  assign w_accept   = s_valid && s_ready;

  assign w_load_state = w_clr_load ? '0   : w_rdata[STATE_W-1:0];
  assign w_load_match = w_clr_load ? 1'b0 : w_rdata[STATE_W];

  // Single write port: a clear always wins; SAVE only writes when the port is free.
  assign w_we    = ctx_clr_vld || w_save_we;
  assign w_waddr = ctx_clr_vld ? ctx_clr_flow : r_cur_flow;
  assign w_wdata = ctx_clr_vld ? '0 : {r_pkt_match, state_out};

  dpi_ctx_ram #(
    .DEPTH (N_FLOW),
    .AW    (FLOW_W),
    .W     (CTX_W)
  ) u_ctx_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (s_flow),
    .o_rdata (w_rdata)
  );

  assign char_in     = s_data;
  assign char_in_vld = w_accept;
  assign state_in    = w_load_state;
  assign res_vld     = r_res_vld;
  assign res_flow    = r_res_flow;
  assign res_match   = r_res_match;

  // Next-state, context bookkeeping and handshake decode.
  always_comb begin
    w_state_next     = r_state;
    w_loaded_next    = r_loaded;
    w_cur_flow_next  = r_cur_flow;
    w_pkt_match_next = r_pkt_match;
    s_ready          = 1'b0;
    state_in_vld     = 1'b0;
    w_save_we        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (s_valid && !w_clr_cur) begin
          if (w_switch) begin
            w_state_next = r_loaded ? ST_SAVE : ST_LOAD;
          end else begin
            w_state_next = ST_RUN;
          end
        end
      end

      ST_SAVE: begin
        if (w_clr_cur) begin
          // The context being saved was just zeroed; drop it instead of writing.
          w_state_next = ST_IDLE;
        end else if (!ctx_clr_vld) begin
          w_save_we     = 1'b1;
          w_loaded_next = 1'b0;
          w_state_next  = ST_LOAD;
        end
        // A clear to another flow holds the write port; retry the save next cycle.
      end

      ST_LOAD: begin
        if (s_valid) begin
          state_in_vld     = 1'b1;
          w_pkt_match_next = w_load_match;
          w_cur_flow_next  = s_flow;
          w_loaded_next    = 1'b1;
          w_state_next     = ST_RUN;
        end else begin
          // Source withdrew the byte; nothing to restore for.
          w_state_next = ST_IDLE;
        end
      end

      ST_RUN: begin
        s_ready = (s_flow == r_cur_flow) && !w_clr_cur;
        if (w_clr_cur) begin
          w_state_next = ST_IDLE;
        end else if (w_switch) begin
          w_state_next = ST_SAVE;
        end else if (s_valid) begin
          // End of packet restarts the sticky verdict; DFA state carries on.
          w_pkt_match_next = s_eop ? 1'b0 : (r_pkt_match | accept_out);
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_clr_cur) begin
      w_loaded_next    = 1'b0;
      w_pkt_match_next = 1'b0;
    end
  end

  // FSM and context registers, plus the one-cycle verdict pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_loaded    <= 1'b0;
      r_cur_flow  <= '0;
      r_pkt_match <= 1'b0;
      r_res_vld   <= 1'b0;
      r_res_flow  <= '0;
      r_res_match <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_loaded    <= w_loaded_next;
      r_cur_flow  <= w_cur_flow_next;
      r_pkt_match <= w_pkt_match_next;
      r_res_vld   <= w_accept && s_eop;
      r_res_flow  <= (w_accept && s_eop) ? r_cur_flow : '0;
      r_res_match <= w_accept && s_eop && (r_pkt_match | accept_out);
    end
  end

endmodule

// File: tb/tb_dpi_flow_sched.sv
// Bench for dpi_flow_sched with a tiny "OK" substring DFA as the engine.
module tb_dpi_flow_sched;

  localparam int FW = 4;
  localparam int SW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = '0;
  logic [FW-1:0] s_flow = '0;
  logic          s_eop = 1'b0;
  logic          ctx_clr_vld = 1'b0;
  logic [FW-1:0] ctx_clr_flow = '0;
  logic [7:0]    char_in;
  logic          char_in_vld;
  logic [SW-1:0] state_in;
  logic          state_in_vld;
  logic [SW-1:0] state_out;
  logic          accept_out;
  logic          res_vld;
  logic [FW-1:0] res_flow;
  logic          res_match;

  dpi_flow_sched #(.N_FLOW(16), .FLOW_W(FW), .STATE_W(SW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_flow       (s_flow),
    .s_eop        (s_eop),
    .ctx_clr_vld  (ctx_clr_vld),
    .ctx_clr_flow (ctx_clr_flow),
    .char_in      (char_in),
    .char_in_vld  (char_in_vld),
    .state_in     (state_in),
    .state_in_vld (state_in_vld),
    .state_out    (state_out),
    .accept_out   (accept_out),
    .res_vld      (res_vld),
    .res_flow     (res_flow),
    .res_match    (res_match)
  );

  always #5 clk = ~clk;

  // Engine stub: state 1 means "just saw O"; accepts on K from state 1.
  logic [SW-1:0] dfa_state;
  assign state_out  = dfa_state;
  assign accept_out = char_in_vld && (dfa_state == SW'(1)) && (char_in == 8'h4B);
  always @(posedge clk) begin
    if (!rst_n)            dfa_state <= '0;
    else if (state_in_vld) dfa_state <= state_in;
    else if (char_in_vld)  dfa_state <= (char_in == 8'h4F) ? SW'(1) : SW'(0);
  end

  typedef struct {
    logic [FW-1:0] flow;
    string         bytes;
    bit            eop;
    bit            clr;
    logic [FW-1:0] clr_flow;
    bit            exp_match;
    int            exp_loads;
  } vec_t;

  typedef struct {
    logic [FW-1:0] flow;
    bit            match;
  } res_t;

  vec_t tbl[$];
  res_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int n_sent = 0;
  int n_chars = 0;
  int n_loads = 0;
  logic [SW-1:0] last_state_in = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic add_vec(input logic [FW-1:0] f, input string b, input bit e, input bit c,
                         input logic [FW-1:0] cf, input bit m, input int l);
    vec_t v;
    v.flow = f; v.bytes = b; v.eop = e; v.clr = c;
    v.clr_flow = cf; v.exp_match = m; v.exp_loads = l;
    tbl.push_back(v);
  endtask

  // Called at negedge+1 with a byte on the bus; returns at the accepting edge.
  task automatic wait_accept(input logic [FW-1:0] f, input bit e, input bit m);
    int   budget;
    res_t r;
    budget = 20;
    while (!s_ready && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout flow=%0d actual s_ready=0 required=1", f);
    end else begin
      @(posedge clk);
      n_sent++;
      if (e) begin
        r.flow = f;
        r.match = m;
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic send_byte(input logic [FW-1:0] f, input logic [7:0] d, input bit e, input bit m);
    @(negedge clk);
    s_valid = 1'b1; s_flow = f; s_data = d; s_eop = e;
    #1;
    wait_accept(f, e, m);
  endtask

  // Mid-cycle monitor: counts engine strobes, checks exclusivity and verdicts.
  always @(negedge clk) begin
    res_t e;
    #2;
    if (char_in_vld) n_chars++;
    if (state_in_vld) begin
      n_loads++;
      last_state_in = state_in;
    end
    chk("vld_exclusive", 32'(state_in_vld & char_in_vld), 32'd0);
    if (res_vld) begin
      if (exp_q.size() == 0) begin
        chk("res_unexpected", 32'(res_vld), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("res_flow", 32'(res_flow), 32'(e.flow));
        chk("res_match", 32'(res_match), 32'(e.match));
        $display("RES flow=%0d match=%0d exp_flow=%0d exp_match=%0d", res_flow, res_match, e.flow, e.match);
      end
    end else begin
      chk("res_idle_zero", 32'({res_flow, res_match}), 32'd0);
    end
  end

  initial begin
    int c0;
    int l0;
    int n;

    // Reset state, with a byte offered to show the scheduler ignores it.
    repeat (3) @(negedge clk);
    s_valid = 1'b1; s_flow = 4'd3; s_data = 8'h41;
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_char_vld", 32'(char_in_vld), 32'd0);
    chk("rst_state_vld", 32'(state_in_vld), 32'd0);
    chk("rst_res_vld", 32'(res_vld), 32'd0);
    chk("rst_res", 32'({res_flow, res_match}), 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b1;

    //      flow   bytes          eop  clr  clrf  match loads
    add_vec(4'd3, "* OK",        1'b1, 1'b0, 4'd0, 1'b1, 1);
    add_vec(4'd1, "a O",         1'b0, 1'b0, 4'd0, 1'b0, 1);
    add_vec(4'd2, "xyz",         1'b1, 1'b0, 4'd0, 1'b0, 1);
    add_vec(4'd1, "K",           1'b1, 1'b0, 4'd0, 1'b1, 1);
    add_vec(4'd5, "OKabcdefgh",  1'b1, 1'b0, 4'd0, 1'b1, 1);
    add_vec(4'd5, "abcdefghij",  1'b1, 1'b0, 4'd0, 1'b0, 0);
    add_vec(4'd1, "a O",         1'b0, 1'b0, 4'd0, 1'b0, 1);
    add_vec(4'd1, "K",           1'b1, 1'b1, 4'd1, 1'b0, 1);
    add_vec(4'd7, "O",           1'b1, 1'b0, 4'd0, 1'b0, 1);
    add_vec(4'd7, "K",           1'b1, 1'b0, 4'd0, 1'b1, 0);

    foreach (tbl[i]) begin
      if (tbl[i].clr) begin
        @(negedge clk);
        s_valid = 1'b0;
        ctx_clr_vld = 1'b1;
        ctx_clr_flow = tbl[i].clr_flow;
        @(negedge clk);
        ctx_clr_vld = 1'b0;
      end
      c0 = n_chars;
      l0 = n_loads;
      n = tbl[i].bytes.len();
      for (int j = 0; j < n; j++) begin
        send_byte(tbl[i].flow, tbl[i].bytes[j], tbl[i].eop && (j == n - 1), tbl[i].exp_match);
      end
      chk($sformatf("vec%0d_chars", i), 32'(n_chars - c0), 32'(n));
      chk($sformatf("vec%0d_loads", i), 32'(n_loads - l0), 32'(tbl[i].exp_loads));
    end
    @(negedge clk);
    s_valid = 1'b0;

    // Clear of flow 4 lands exactly on its SAVE cycle.
    send_byte(4'd4, 8'h4F, 1'b0, 1'b0);
    @(negedge clk);
    s_valid = 1'b1; s_flow = 4'd0; s_data = 8'h7A; s_eop = 1'b1;
    #1;
    chk("swap_detect_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    ctx_clr_vld = 1'b1; ctx_clr_flow = 4'd4;
    #1;
    chk("save_no_load", 32'(state_in_vld), 32'd0);
    @(negedge clk);
    ctx_clr_vld = 1'b0;
    #1;
    chk("idle_after_clr_save", 32'(state_in_vld), 32'd0);
    @(negedge clk);
    #1;
    chk("load_after_idle", 32'(state_in_vld), 32'd1);
    wait_accept(4'd0, 1'b1, 1'b0);
    send_byte(4'd4, 8'h4B, 1'b1, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk("clr_save_restore", 32'(last_state_in), 32'd0);

    // Reset in the middle of a flow-2 packet, with flow 6 holding saved state.
    send_byte(4'd6, 8'h4F, 1'b0, 1'b0);
    send_byte(4'd2, 8'h4F, 1'b0, 1'b0);
    send_byte(4'd2, 8'h4B, 1'b0, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    s_valid = 1'b1; s_flow = 4'd6; s_data = 8'h4B; s_eop = 1'b1;
    #1;
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    chk("midrst_char_vld", 32'(char_in_vld), 32'd0);
    chk("midrst_state_vld", 32'(state_in_vld), 32'd0);
    chk("midrst_res_vld", 32'(res_vld), 32'd0);
    chk("midrst_res", 32'({res_flow, res_match}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    l0 = n_loads;
    #1;
    wait_accept(4'd6, 1'b1, 1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    chk("postrst_loads", 32'(n_loads - l0), 32'd1);
    chk("postrst_state_in", 32'(last_state_in), 32'd0);

    repeat (4) @(negedge clk);
    #3;
    chk("res_missing", 32'(exp_q.size()), 32'd0);
    chk("char_total", 32'(n_chars), 32'(n_sent));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
